// File: rtl/full_adder_core.sv
// full_adder_core: ripple-carry adder slice with registered sum, carry, overflow and zero flags
module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             out_valid,
    output logic             overflow,
    output logic             zero
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_d, s_q;
    logic             c_out_d, c_out_q;
    logic             out_valid_d, out_valid_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    // Idle cycles hold the last result so operands are don't-care while in_valid is low
    always_comb begin
        s_d         = in_valid ? sum : s_q;
        c_out_d     = in_valid ? carry[WIDTH] : c_out_q;
        overflow_d  = in_valid ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) : overflow_q;
        zero_d      = in_valid ? (sum == '0) : zero_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign s         = s_q;
    assign c_out     = c_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: randomized and directed checks of WIDTH 1, 6 and 16 adders against an arithmetic model
module tb_full_adder_core;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        c_in;
    logic [63:0] op_a [3];
    logic [63:0] op_b [3];
    int          wl [3] = '{1, 6, 16};

    logic [0:0]  a1, b1, s1;
    logic [5:0]  a6, b6, s6;
    logic [15:0] a16, b16, s16;
    logic        c1, v1, o1, z1;
    logic        c6, v6, o6, z6;
    logic        c16, v16, o16, z16;

    logic [63:0] es [3];
    logic        ec [3], eo [3], ez [3], ev [3];

    int n_tests = 0;
    int n_fail  = 0;

    assign a1  = op_a[0][0:0];
    assign b1  = op_b[0][0:0];
    assign a6  = op_a[1][5:0];
    assign b6  = op_b[1][5:0];
    assign a16 = op_a[2][15:0];
    assign b16 = op_b[2][15:0];

    full_adder_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .c_in(c_in),
        .s(s1), .c_out(c1), .out_valid(v1), .overflow(o1), .zero(z1)
    );
    full_adder_core #(.WIDTH(6)) u_w6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a6), .b(b6), .c_in(c_in),
        .s(s6), .c_out(c6), .out_valid(v6), .overflow(o6), .zero(z6)
    );
    full_adder_core #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .c_in(c_in),
        .s(s16), .c_out(c16), .out_valid(v16), .overflow(o16), .zero(z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned sum for s/c_out, signed range test for overflow
    function automatic void model(int w, logic [63:0] a, logic [63:0] b, logic ci,
                                  output logic [63:0] s, output logic c, output logic ov,
                                  output logic z);
        longint mask, t, sa, sb, ss;
        mask = (longint'(1) << w) - 1;
        t    = (longint'(a) & mask) + (longint'(b) & mask) + longint'(ci);
        s    = 64'(t & mask);
        c    = ((t >> w) & 1) != 0;
        sa   = a[w-1] ? (longint'(a) & mask) - (longint'(1) << w) : (longint'(a) & mask);
        sb   = b[w-1] ? (longint'(b) & mask) - (longint'(1) << w) : (longint'(b) & mask);
        ss   = sa + sb + longint'(ci);
        ov   = (ss > (longint'(1) << (w - 1)) - 1) || (ss < -(longint'(1) << (w - 1)));
        z    = (s == 0);
    endfunction

    task automatic check_all(string tag);
        check({tag, " w1 s"}, 64'(s1), es[0]);
        check({tag, " w1 c_out"}, 64'(c1), 64'(ec[0]));
        check({tag, " w1 ovf"}, 64'(o1), 64'(eo[0]));
        check({tag, " w1 zero"}, 64'(z1), 64'(ez[0]));
        check({tag, " w1 valid"}, 64'(v1), 64'(ev[0]));
        check({tag, " w6 s"}, 64'(s6), es[1]);
        check({tag, " w6 c_out"}, 64'(c6), 64'(ec[1]));
        check({tag, " w6 ovf"}, 64'(o6), 64'(eo[1]));
        check({tag, " w6 zero"}, 64'(z6), 64'(ez[1]));
        check({tag, " w6 valid"}, 64'(v6), 64'(ev[1]));
        check({tag, " w16 s"}, 64'(s16), es[2]);
        check({tag, " w16 c_out"}, 64'(c16), 64'(ec[2]));
        check({tag, " w16 ovf"}, 64'(o16), 64'(eo[2]));
        check({tag, " w16 zero"}, 64'(z16), 64'(ez[2]));
        check({tag, " w16 valid"}, 64'(v16), 64'(ev[2]));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                es[k] = '0; ec[k] = 0; eo[k] = 0; ez[k] = 0; ev[k] = 0;
            end else if (in_valid) begin
                model(wl[k], op_a[k], op_b[k], c_in, es[k], ec[k], eo[k], ez[k]);
                ev[k] = 1'b1;
            end else begin
                ev[k] = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_op(logic [63:0] a, logic [63:0] b, logic ci);
        for (int k = 0; k < 3; k++) begin
            op_a[k] = a;
            op_b[k] = b;
        end
        c_in = ci;
    endtask

    logic [5:0] ex [6] = '{6'b000_001, 6'b100_100, 6'b010_100, 6'b001_100, 6'b110_011, 6'b111_110};
    logic [5:0] wa [3] = '{6'h3F, 6'h1F, 6'h20};
    logic [5:0] wb [3] = '{6'h01, 6'h01, 6'h20};
    logic [5:0] ws [3] = '{6'h00, 6'h20, 6'h00};
    logic [2:0] wf [3] = '{3'b110, 3'b001, 3'b111};
    logic [5:0] ba [3] = '{6'd1, 6'd10, 6'd63};
    logic [5:0] bb [3] = '{6'd2, 6'd20, 6'd63};
    logic       bc [3] = '{1'b0, 1'b1, 1'b1};
    logic [5:0] bs [3] = '{6'd3, 6'd31, 6'd63};

    initial begin
        logic [5:0] row;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        set_op('1, '1, 1'b1);
        for (int r = 0; r < 2; r++) begin
            step("reset");
            check("reset zero w6", 64'(z6), 64'd0);
            check("reset valid w1", 64'(v1), 64'd0);
            check("reset s w16", 64'(s16), 64'd0);
        end
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            row = ex[r];
            in_valid = 1'b1;
            set_op(64'(row[5]), 64'(row[4]), row[3]);
            step("exh");
            check("exh s", 64'(s1), 64'(row[2]));
            check("exh c_out", 64'(c1), 64'(row[1]));
            check("exh zero", 64'(z1), 64'(row[0]));
            check("exh valid", 64'(v1), 64'd1);
        end

        for (int r = 0; r < 3; r++) begin
            set_op(64'(wa[r]), 64'(wb[r]), 1'b0);
            step("w6dir");
            check("w6dir s", 64'(s6), 64'(ws[r]));
            check("w6dir c_out", 64'(c6), 64'(wf[r][2]));
            check("w6dir zero", 64'(z6), 64'(wf[r][1]));
            check("w6dir ovf", 64'(o6), 64'(wf[r][0]));
        end

        set_op(64'd5, 64'd9, 1'b1);
        step("hold acc");
        check("hold acc s", 64'(s6), 64'd15);
        in_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            step("hold");
            check("hold s", 64'(s6), 64'd15);
            check("hold valid", 64'(v6), 64'd0);
        end

        in_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_op(64'(ba[r]), 64'(bb[r]), bc[r]);
            step("b2b");
            check("b2b s", 64'(s6), 64'(bs[r]));
            check("b2b valid", 64'(v6), 64'd1);
        end
        rst_n = 1'b0;
        set_op(64'd7, 64'd7, 1'b0);
        step("midrst");
        check("midrst valid", 64'(v6), 64'd0);
        check("midrst s", 64'(s6), 64'd0);
        check("midrst c_out", 64'(c6), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("postrst");
        check("postrst s", 64'(s6), 64'd0);

        for (int n = 0; n < 10000; n++) begin
            in_valid = 1'($urandom);
            c_in     = 1'($urandom);
            for (int k = 0; k < 3; k++) begin
                op_a[k] = {$urandom, $urandom};
                op_b[k] = {$urandom, $urandom};
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/full_adder_core.md
# full_adder_core

Clocked full-adder slice for the 6-bit CPU datapath. Adds two WIDTH-bit operands and a carry-in through an explicit ripple chain of 1-bit full-adder cells. Registers the sum, carry-out and status flags one cycle later. With WIDTH=1 it is the single-bit full adder; with WIDTH=6 it is the ALU adder.

## Interface
Parameters:
- WIDTH, default 1: operand and sum width in bits; legal range 1–32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  high marks a, b, c_in as a valid operation this cycle.
- a  input  WIDTH  operand A, unsigned or two's-complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- s  output  WIDTH  registered sum bits.
- c_out  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  high for one cycle per accepted operation.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered flag, high when s is all zeros.

## Operation
- Combinational core: a chain of WIDTH 1-bit full-adder cells.
  - Cell i: sum_i = a[i] ^ b[i] ^ carry_i.
  - Cell i: carry_{i+1} = (a[i] & b[i]) | (a[i] & carry_i) | (b[i] & carry_i).
  - carry_0 = c_in.
- Result is defined as {c_out, s} = a + b + c_in, computed modulo 2^(WIDTH+1). No saturation. Wrap-around is signalled only through c_out and overflow.
- overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]). It uses the same-cycle a, b and sum.
- For WIDTH=1, overflow equals carry_1 XOR carry_0.
- zero = (sum == 0). The flag ignores c_out.
- Accept rule: on a rising edge with rst_n=1 and in_valid=1, the block does all of:
  - registers s, c_out, overflow and zero from the combinational core;
  - sets out_valid=1.
- On a rising edge with rst_n=1 and in_valid=0:
  - out_valid goes to 0;
  - s, c_out, overflow and zero hold their last values.
- No backpressure. A new operation can be accepted every cycle. Back-to-back operations produce back-to-back out_valid pulses.
- Inputs sampled while in_valid=0 have no effect, including X values.

## Timing
- Latency: exactly 1 cycle. Operands sampled at edge N appear on s, c_out, overflow and zero after edge N. out_valid is high in the cycle after edge N.
- Throughput: one operation per cycle.
- Reset: on a rising edge with rst_n=0, s, c_out, overflow, out_valid and zero all become 0. Reset overrides in_valid.
- Outputs stay at 0 until the first accepted operation after rst_n returns high.
- The reset value of zero is 0, not 1.
- Reset mid-stream: an operation presented in the same cycle as reset is discarded. No out_valid is produced for it.
- Before the first clock edge, outputs are undefined. Benches must apply reset first.
- All outputs come directly from flops. There is no combinational input-to-output path.

## Test plan
- Exhaustive 1-bit check, WIDTH=1, after reset. Each row applies (a,b,c_in) with in_valid=1, then checks the next cycle:
  - (0,0,0) gives s=0, c_out=0, zero=1.
  - (1,0,0) gives s=1, c_out=0.
  - (0,1,0) gives s=1, c_out=0.
  - (0,0,1) gives s=1, c_out=0.
  - (1,1,0) gives s=0, c_out=1.
  - (1,1,1) gives s=1, c_out=1.
  - out_valid=1 every cycle.
- Reset values: hold rst_n=0 with in_valid=1, a=1, b=1 for 2 edges. Required: s=0, c_out=0, overflow=0, zero=0, out_valid=0.
- WIDTH=6 wrap and overflow:
  - a=6'h3F, b=6'h01, c_in=0 gives s=0, c_out=1, zero=1, overflow=0.
  - a=6'h1F, b=6'h01 gives s=6'h20, c_out=0, overflow=1.
  - a=6'h20, b=6'h20 gives s=0, c_out=1, overflow=1, zero=1.
- Hold behaviour: accept a=5, b=9, c_in=1 (WIDTH=6), giving s=15. Then drop in_valid and change a and b randomly for 3 cycles. Required: s stays 15 and out_valid=0 for those cycles.
- Back-to-back with reset mid-stream: stream 3 valid operations on consecutive cycles, then assert rst_n=0 with a 4th operation.
  - Required: 3 consecutive out_valid pulses with the correct sums.
  - The 4th operation is discarded and all outputs are 0.
- Random sweep: 10k random a, b and c_in, with in_valid toggled randomly. Compare every out_valid result against the reference model a+b+c_in for WIDTH in {1, 6, 16}.
